// File: rtl/adder16_arb_pkg.sv
// Shared constants for the adder16 arbiter slice.
//   - state_e   : FSM state encoding (IDLE / CALC / RESP)
//   - REQ0/REQ1 : requester identifiers, used for grant and priority
//   - ADD_W     : datapath width of the shared adder
package adder16_arb_pkg;

  localparam int ADD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder16_arbiter_adder16.sv
// Shared combinational 16-bit unsigned adder.
// Ports:
//   s    : output, a + b modulo 2^16
//   ovfl : output, unsigned carry-out of a + b
//   a, b : input operands
module adder16
  import adder16_arb_pkg::*;
(
  output logic [ADD_W-1:0] s,
  output logic             ovfl,
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b
);

  // 17-bit sum so the carry-out falls out as the top bit.
  assign {ovfl, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder16_arbiter.sv
// Time-shares one adder16 between two requesters.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   reqX_valid/_a/_b/_ready  : operand request channel of requester X
//   respX_valid/_ready       : response channel of requester X
//   resp_s, resp_ovfl        : registered sum / carry-out shared by both
//                              response channels
// RR=1 alternates priority after every completed operation; RR=0 always
// favours requester 0 on contention.
module adder16_arbiter
  import adder16_arb_pkg::*;
#(
  parameter bit RR = 1'b1,
  parameter int W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [W-1:0] resp_s,
  output logic         resp_ovfl
);

  generate
    if (W != ADD_W) begin : g_bad_width
      $error("adder16_arbiter: W must be 16");
    end
  endgenerate

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic           gnt_q, gnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   s_q, s_d;
  logic           ovfl_q, ovfl_d;
  logic           resp0_valid_q, resp0_valid_d;
  logic           resp1_valid_q, resp1_valid_d;

  logic           win_s;
  logic           idle_s;
  logic           resp_take_s;
  logic [W-1:0]   sum_s;
  logic           carry_s;

  // Adder sees only the latched operands, never the live request buses.
  adder16 u_adder16 (
    .s    (sum_s),
    .ovfl (carry_s),
    .a    (a_q),
    .b    (b_q)
  );

  // Winner selection among the currently valid requests.
  always_comb begin
    win_s = REQ0;
    if (req0_valid && req1_valid) begin
      win_s = (RR != 1'b0) ? prio_q : REQ0;
    end else if (req1_valid) begin
      win_s = REQ1;
    end else begin
      win_s = REQ0;
    end
  end

  // Readys gated by rst so nothing is accepted while reset is held.
  assign idle_s     = (state_q == IDLE) && !rst;
  assign req0_ready = idle_s && req0_valid && (win_s == REQ0);
  assign req1_ready = idle_s && req1_valid && (win_s == REQ1);

  // Only the granted requester's resp_ready completes the response.
  assign resp_take_s = (gnt_q == REQ1) ? resp1_ready : resp0_ready;

  // Next-state and datapath update logic.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    gnt_d         = gnt_q;
    a_d           = a_q;
    b_d           = b_q;
    s_d           = s_q;
    ovfl_d        = ovfl_q;
    resp0_valid_d = resp0_valid_q;
    resp1_valid_d = resp1_valid_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = win_s;
          a_d     = (win_s == REQ1) ? req1_a : req0_a;
          b_d     = (win_s == REQ1) ? req1_b : req0_b;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        s_d     = sum_s;
        ovfl_d  = carry_s;
        state_d = RESP;
        if (gnt_q == REQ1) begin
          resp0_valid_d = 1'b0;
          resp1_valid_d = 1'b1;
        end else begin
          resp0_valid_d = 1'b1;
          resp1_valid_d = 1'b0;
        end
      end
      RESP: begin
        if (resp_take_s) begin
          resp0_valid_d = 1'b0;
          resp1_valid_d = 1'b0;
          state_d       = IDLE;
          if (RR != 1'b0) begin
            prio_d = ~gnt_q;
          end else begin
            prio_d = prio_q;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d       = IDLE;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      prio_q        <= REQ0;
      gnt_q         <= REQ0;
      a_q           <= 16'h0000;
      b_q           <= 16'h0000;
      s_q           <= 16'h0000;
      ovfl_q        <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      gnt_q         <= gnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      s_q           <= s_d;
      ovfl_q        <= ovfl_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp_s      = s_q;
  assign resp_ovfl   = ovfl_q;

endmodule

// File: tb/tb_adder16_arbiter.sv
// Directed bench for adder16_arbiter: one round-robin instance and one
// fixed-priority instance share the same stimulus.
module tb_adder16_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_ready, resp1_ready;

  logic        r_req0_ready, r_req1_ready, r_resp0_valid, r_resp1_valid, r_ovfl;
  logic [15:0] r_s;
  logic        f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid, f_ovfl;
  logic [15:0] f_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder16_arbiter #(.RR(1'b1), .W(16)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r_req1_ready),
    .resp0_valid(r_resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(r_resp1_valid), .resp1_ready(resp1_ready),
    .resp_s(r_s), .resp_ovfl(r_ovfl)
  );

  adder16_arbiter #(.RR(1'b0), .W(16)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(f_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(f_req1_ready),
    .resp0_valid(f_resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(f_resp1_valid), .resp1_ready(resp1_ready),
    .resp_s(f_s), .resp_ovfl(f_ovfl)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One clock, then 1 time unit past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 16'h0000; req0_b = 16'h0000; req1_a = 16'h0000; req1_b = 16'h0000;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // Reset state: nothing accepted or presented while rst is high.
    #3;
    chk("rst_req0_ready", {31'd0, r_req0_ready}, 32'd0);
    chk("rst_resp0_valid", {31'd0, r_resp0_valid}, 32'd0);
    chk("rst_resp_s", {16'd0, r_s}, 32'd0);
    chk("rst_ovfl", {31'd0, r_ovfl}, 32'd0);
    cyc();
    req0_valid = 1'b0;
    rst = 1'b0;

    // Ten idle cycles, no response appears.
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_resp_valid", {30'd0, r_resp0_valid, r_resp1_valid}, 32'd0);
    end

    // Single request: 0x1D67 + 0xE38C = 0x1_00F3.
    req0_valid = 1'b1; req0_a = 16'h1D67; req0_b = 16'hE38C; resp0_ready = 1'b1;
    #1;
    chk("single_req0_ready", {31'd0, r_req0_ready}, 32'd1);
    cyc();                                   // edge N: accept
    req0_valid = 1'b0;
    #1;
    chk("single_calc_ready", {31'd0, r_req0_ready}, 32'd0);
    chk("single_calc_valid", {31'd0, r_resp0_valid}, 32'd0);
    cyc();                                   // edge N+1
    chk("single_resp0_valid", {31'd0, r_resp0_valid}, 32'd1);
    chk("single_resp1_valid", {31'd0, r_resp1_valid}, 32'd0);
    chk("single_s", {16'd0, r_s}, 32'h0000_00F3);
    chk("single_ovfl", {31'd0, r_ovfl}, 32'd1);
    cyc();                                   // edge N+2: response handshake
    chk("single_valid_drop", {31'd0, r_resp0_valid}, 32'd0);
    chk("single_s_hold", {16'd0, r_s}, 32'h0000_00F3);
    req0_valid = 1'b1;
    #1;
    chk("single_back_idle", {31'd0, r_req0_ready}, 32'd1);
    req0_valid = 1'b0;
    resp0_ready = 1'b0;
    #1;

    // Backpressure on requester 1: 0x40C0 + 0x2FA1 = 0x7061.
    cyc();
    req1_valid = 1'b1; req1_a = 16'h40C0; req1_b = 16'h2FA1; resp1_ready = 1'b0;
    #1;
    chk("bp_req1_ready", {31'd0, r_req1_ready}, 32'd1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    // Other side's resp_ready must be ignored; new requests must be blocked.
    resp0_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_resp1_valid", {31'd0, r_resp1_valid}, 32'd1);
      chk("bp_resp0_valid", {31'd0, r_resp0_valid}, 32'd0);
      chk("bp_s", {16'd0, r_s}, 32'h0000_7061);
      chk("bp_ovfl", {31'd0, r_ovfl}, 32'd0);
      chk("bp_readys", {30'd0, r_req0_ready, r_req1_ready}, 32'd0);
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b1;
    cyc();
    chk("bp_release", {31'd0, r_resp1_valid}, 32'd0);
    resp1_ready = 1'b0;

    // Contention: req0 0xFFFF+0xFFFF, req1 0x0000+0x0000, both always valid.
    req0_a = 16'hFFFF; req0_b = 16'hFFFF; req1_a = 16'h0000; req1_b = 16'h0000;
    req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 1);
      chk("rr_ready", {30'd0, r_req1_ready, r_req0_ready}, g ? 32'd2 : 32'd1);
      chk("fp_ready", {30'd0, f_req1_ready, f_req0_ready}, 32'd1);
      cyc();
      chk("rr_calc_ready", {30'd0, r_req1_ready, r_req0_ready}, 32'd0);
      chk("fp_calc_ready", {30'd0, f_req1_ready, f_req0_ready}, 32'd0);
      cyc();
      chk("rr_resp_valid", {30'd0, r_resp1_valid, r_resp0_valid}, g ? 32'd2 : 32'd1);
      chk("rr_resp_sum", {15'd0, r_ovfl, r_s}, g ? 32'h0_0000 : 32'h1_FFFE);
      chk("fp_resp_valid", {30'd0, f_resp1_valid, f_resp0_valid}, 32'd1);
      chk("fp_resp_sum", {15'd0, f_ovfl, f_s}, 32'h1_FFFE);
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
    cyc();

    // Reset during RESP: 0x0001 + 0x0002.
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002;
    cyc();
    req0_valid = 1'b0;
    cyc();
    chk("rstresp_valid_pre", {31'd0, r_resp0_valid}, 32'd1);
    chk("rstresp_s_pre", {16'd0, r_s}, 32'h0000_0003);
    #2;
    rst = 1'b1;
    #1;
    chk("rstresp_async_valid", {30'd0, r_resp1_valid, r_resp0_valid}, 32'd0);
    chk("rstresp_async_sum", {15'd0, r_ovfl, r_s}, 32'd0);
    cyc();
    rst = 1'b0;
    // prio back to req0 after reset.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rstresp_prio", {30'd0, r_req1_ready, r_req0_ready}, 32'd1);
    req0_valid = 1'b0; req1_a = 16'h1234; req1_b = 16'h4321; resp1_ready = 1'b1;
    #1;
    chk("rstresp_req1_ready", {31'd0, r_req1_ready}, 32'd1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk("rstresp_req1_valid", {30'd0, r_resp1_valid, r_resp0_valid}, 32'd2);
    chk("rstresp_req1_sum", {15'd0, r_ovfl, r_s}, 32'h0_5555);
    cyc();
    chk("rstresp_req1_done", {31'd0, r_resp1_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
